// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: hazard-request and pipeline-control bundle between the
// 5-stage core datapath (master) and the stall/flush scheduler (slave).
interface pipe_hazard_if #(
  parameter int CNT_W = 64
) ();
  // hazard / completion requests from the pipeline
  logic             ifu_busy;
  logic             load_use;
  logic             redirect;
  logic             trap;
  logic             lsu_req;
  logic             lsu_done;
  logic             mdu_req;
  logic             mdu_done;
  // pipeline register controls back to the datapath
  logic             pc_stall;
  logic             if_id_stall;
  logic             id_ex_stall;
  logic             ex_mem_stall;
  logic             mem_wb_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mdu_kill;
  logic             timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output ifu_busy, load_use, redirect, trap, lsu_req, lsu_done, mdu_req, mdu_done,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
    input  if_id_flush, id_ex_flush, ex_mem_flush, mdu_kill, timeout,
    input  stall_cycles, flush_events
  );

  modport slave (
    input  ifu_busy, load_use, redirect, trap, lsu_req, lsu_done, mdu_req, mdu_done,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
    output if_id_flush, id_ex_flush, ex_mem_flush, mdu_kill, timeout,
    output stall_cycles, flush_events
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush scheduler for the 5-stage RV64 core.
// Resolves trap > LSU miss > redirect > MDU busy > load-use > fetch miss,
// tracks multi-cycle LSU/MDU waits with a watchdog, and raises a sticky
// timeout flag when a wait is aborted. Controls are Mealy (state + inputs).
// Optional build macro PIPE_HAZARD_PERF_EN adds stall/flush perf counters;
// without it both counter ports read zero and no counter flops exist.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 64
) (
  input logic          clk,
  input logic          rst_n,
  pipe_hazard_if.slave hz
);

  localparam int WCW = $clog2(TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LSU_WAIT = 2'd1;
  localparam logic [1:0] ST_MDU_WAIT = 2'd2;

  logic [1:0]     state_r;
  logic [1:0]     state_nxt_s;
  logic [WCW-1:0] wait_cnt_r;
  logic [WCW-1:0] wait_cnt_nxt_s;
  logic           timeout_r;
  logic           abort_s;
  logic           run_eval_s;
  logic           lsu_row_en_s;

  logic pc_stall_s, if_id_stall_s, id_ex_stall_s, ex_mem_stall_s, mem_wb_stall_s;
  logic if_id_flush_s, id_ex_flush_s, ex_mem_flush_s, mdu_kill_s;

  // Mealy control decode: wait-state holds, watchdog abort, then RUN priority rows
  always_comb begin
    pc_stall_s     = 1'b0;
    if_id_stall_s  = 1'b0;
    id_ex_stall_s  = 1'b0;
    ex_mem_stall_s = 1'b0;
    mem_wb_stall_s = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_flush_s = 1'b0;
    mdu_kill_s     = 1'b0;
    state_nxt_s    = state_r;
    abort_s        = 1'b0;
    run_eval_s     = 1'b0;
    lsu_row_en_s   = 1'b0;

    if (!rst_n) begin
      // hold every stage as a bubble while in reset
      if_id_flush_s  = 1'b1;
      id_ex_flush_s  = 1'b1;
      ex_mem_flush_s = 1'b1;
      mdu_kill_s     = 1'b1;
      state_nxt_s    = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          run_eval_s   = 1'b1;
          lsu_row_en_s = 1'b1;
        end
        ST_LSU_WAIT: begin
          if (hz.lsu_done) begin
            // completion cycle: younger hazards resolve now, LSU row excluded
            run_eval_s  = 1'b1;
            state_nxt_s = ST_RUN;
          end else if (wait_cnt_r == WAIT_LAST) begin
            abort_s     = 1'b1;
            state_nxt_s = ST_RUN;
          end else begin
            pc_stall_s     = 1'b1;
            if_id_stall_s  = 1'b1;
            id_ex_stall_s  = 1'b1;
            ex_mem_stall_s = 1'b1;
            mem_wb_stall_s = 1'b1;
          end
        end
        ST_MDU_WAIT: begin
          if (hz.mdu_done) begin
            state_nxt_s = ST_RUN;
          end else if (wait_cnt_r == WAIT_LAST) begin
            abort_s     = 1'b1;
            state_nxt_s = ST_RUN;
          end else begin
            pc_stall_s     = 1'b1;
            if_id_stall_s  = 1'b1;
            id_ex_stall_s  = 1'b1;
            ex_mem_flush_s = 1'b1;
          end
        end
        default: begin
          // unreachable encoding: scrub the pipe and resume
          abort_s     = 1'b1;
          state_nxt_s = ST_RUN;
        end
      endcase

      if (abort_s) begin
        if_id_flush_s  = 1'b1;
        id_ex_flush_s  = 1'b1;
        ex_mem_flush_s = 1'b1;
        mdu_kill_s     = 1'b1;
      end else begin
        abort_s = 1'b0;
      end

      if (run_eval_s) begin
        if (hz.trap) begin
          // PC is free to load the trap vector
          if_id_flush_s  = 1'b1;
          id_ex_flush_s  = 1'b1;
          ex_mem_flush_s = 1'b1;
          mdu_kill_s     = 1'b1;
        end else if (lsu_row_en_s && hz.lsu_req && !hz.lsu_done) begin
          pc_stall_s     = 1'b1;
          if_id_stall_s  = 1'b1;
          id_ex_stall_s  = 1'b1;
          ex_mem_stall_s = 1'b1;
          mem_wb_stall_s = 1'b1;
          state_nxt_s    = ST_LSU_WAIT;
        end else if (hz.redirect) begin
          if_id_flush_s = 1'b1;
          id_ex_flush_s = 1'b1;
          mdu_kill_s    = 1'b1;
        end else if (hz.mdu_req && !hz.mdu_done) begin
          pc_stall_s     = 1'b1;
          if_id_stall_s  = 1'b1;
          id_ex_stall_s  = 1'b1;
          ex_mem_flush_s = 1'b1;
          state_nxt_s    = ST_MDU_WAIT;
        end else if (hz.load_use) begin
          pc_stall_s    = 1'b1;
          if_id_stall_s = 1'b1;
          id_ex_flush_s = 1'b1;
        end else if (hz.ifu_busy) begin
          pc_stall_s    = 1'b1;
          if_id_flush_s = 1'b1;
        end else begin
          pc_stall_s = 1'b0;
        end
      end else begin
        run_eval_s = 1'b0;
      end
    end
  end

  // wait counter runs only while staying in the same wait state
  always_comb begin
    wait_cnt_nxt_s = '0;
    if ((state_nxt_s != ST_RUN) && (state_nxt_s == state_r)) begin
      wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
    end else begin
      wait_cnt_nxt_s = '0;
    end
  end

  // state, watchdog counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= '0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      timeout_r  <= timeout_r | abort_s;
    end
  end

  assign hz.pc_stall     = pc_stall_s;
  assign hz.if_id_stall  = if_id_stall_s;
  assign hz.id_ex_stall  = id_ex_stall_s;
  assign hz.ex_mem_stall = ex_mem_stall_s;
  assign hz.mem_wb_stall = mem_wb_stall_s;
  assign hz.if_id_flush  = if_id_flush_s;
  assign hz.id_ex_flush  = id_ex_flush_s;
  assign hz.ex_mem_flush = ex_mem_flush_s;
  assign hz.mdu_kill     = mdu_kill_s;
  assign hz.timeout      = timeout_r;

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cycles_r;
  logic [CNT_W-1:0] flush_events_r;

  // perf counters: stalled-PC cycles and cycles carrying any flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_r <= '0;
      flush_events_r <= '0;
    end else begin
      if (pc_stall_s) begin
        stall_cycles_r <= stall_cycles_r + CNT_W'(1);
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (if_id_flush_s || id_ex_flush_s || ex_mem_flush_s) begin
        flush_events_r <= flush_events_r + CNT_W'(1);
      end else begin
        flush_events_r <= flush_events_r;
      end
    end
  end

  assign hz.stall_cycles = stall_cycles_r;
  assign hz.flush_events = flush_events_r;
`else
  assign hz.stall_cycles = {CNT_W{1'b0}};
  assign hz.flush_events = {CNT_W{1'b0}};
`endif

endmodule
